// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants for the PDM transmitter and receiver
package pdm_pkg;

    localparam int PDM_DATA_W = 16;

    // Integrator headroom above the sample width for the second-order loop
    localparam int PDM_I1_GUARD = 3;
    localparam int PDM_I2_GUARD = 6;

    // Midscale offset, also the magnitude of the modulator feedback
    function automatic int pdm_midscale(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - PDM bit clock divider with rise/fall ticks
module pdm_clk_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clk_div,
    output logic        clk_out,
    output logic        rise_tick,
    output logic        fall_tick
);

    logic [31:0] cnt;
    logic        tc;

    // clk_div is compared live; >= keeps a shrinking divider from running to 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tc      <= 1'b1;
            clk_out <= 1'b1;
        end else begin
            if (cnt >= clk_div) begin
                cnt <= '0;
                tc  <= 1'b1;
            end else begin
                cnt <= cnt + 32'd1;
                tc  <= 1'b0;
            end
            if (tc) begin
                clk_out <= ~clk_out;
            end
        end
    end

    assign fall_tick = tc & clk_out;
    assign rise_tick = tc & ~clk_out;

endmodule

// File: rtl/pdm_tx.sv
// rtl/pdm_tx.sv - PCM to PDM transmitter; PDM_TX_SECOND_ORDER_EN selects the second-order modulator
module pdm_tx
    import pdm_pkg::*;
#(
    parameter int DATA_W = PDM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       clk_div,
    input  logic [7:0]        osr,
    input  logic [DATA_W-1:0] pcm_in,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    output logic              pdm_clk_out,
    output logic              pdm_data_out,
    output logic              underrun
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(pdm_midscale(DATA_W));

    logic                     fall_tick;
    logic                     unused_rise;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] active;
    logic                     hold_full;
    logic [7:0]               bit_cnt;
    logic                     accept;
    logic                     boundary;
    logic                     next_bit;

    pdm_clk_gen u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .clk_out   (pdm_clk_out),
        .rise_tick (unused_rise),
        .fall_tick (fall_tick)
    );

    assign pcm_ready = ~hold_full;
    assign accept    = pcm_valid & pcm_ready;
    assign boundary  = fall_tick & (bit_cnt == osr);

    // A handshake on a boundary lands in hold; it never bypasses to active
    always_ff @(posedge clk) begin
        if (rst) begin
            hold         <= '0;
            hold_full    <= 1'b0;
            active       <= '0;
            bit_cnt      <= '0;
            underrun     <= 1'b0;
            pdm_data_out <= 1'b0;
        end else begin
            underrun <= boundary & ~hold_full;
            if (accept) begin
                hold      <= pcm_in;
                hold_full <= 1'b1;
            end
            if (fall_tick) begin
                pdm_data_out <= next_bit;
                if (bit_cnt == osr) begin
                    bit_cnt <= '0;
                    if (hold_full) begin
                        active    <= hold;
                        hold_full <= 1'b0;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 8'd1;
                end
            end
        end
    end

`ifdef PDM_TX_SECOND_ORDER_EN
    localparam int I1_W = DATA_W + PDM_I1_GUARD;
    localparam int I2_W = DATA_W + PDM_I2_GUARD;
    localparam logic signed [DATA_W:0] FB_MAG = {1'b0, MID};

    logic signed [DATA_W:0] fb;
    logic signed [I1_W-1:0] i1;
    logic signed [I1_W-1:0] i1_next;
    logic signed [I2_W-1:0] i2;
    logic signed [I2_W-1:0] i2_next;
    logic signed [I1_W+1:0] i1_sum;
    logic signed [I2_W+1:0] i2_sum;

    // Sums carry two guard bits so overflow is detectable before clamping
    always_comb begin
        fb     = pdm_data_out ? FB_MAG : -FB_MAG;
        i1_sum = (I1_W+2)'(i1) + (I1_W+2)'(active) - (I1_W+2)'(fb);
        i2_sum = (I2_W+2)'(i2) + (I2_W+2)'(i1) - (I2_W+2)'(fb);
        if ((&i1_sum[I1_W+1:I1_W-1]) | ~(|i1_sum[I1_W+1:I1_W-1])) begin
            i1_next = i1_sum[I1_W-1:0];
        end else begin
            i1_next = {i1_sum[I1_W+1], {(I1_W-1){~i1_sum[I1_W+1]}}};
        end
        if ((&i2_sum[I2_W+1:I2_W-1]) | ~(|i2_sum[I2_W+1:I2_W-1])) begin
            i2_next = i2_sum[I2_W-1:0];
        end else begin
            i2_next = {i2_sum[I2_W+1], {(I2_W-1){~i2_sum[I2_W+1]}}};
        end
        next_bit = ~i2_next[I2_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
        end else if (fall_tick) begin
            i1 <= i1_next;
            i2 <= i2_next;
        end
    end
`else
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] u;
    logic [DATA_W:0]   sum;

    // Offset-binary input; the carry out of the accumulator is the PDM bit
    always_comb begin
        u        = $unsigned(active) + MID;
        sum      = {1'b0, acc} + {1'b0, u};
        next_bit = sum[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (fall_tick) begin
            acc <= sum[DATA_W-1:0];
        end
    end
`endif

endmodule
